// File: rtl/dmem_access_unit_if.sv
// Execute-side request, memory-port and load_unit-side signals of dmem_access_unit.
// slave is the unit's view; master is the view of the surrounding pipeline/memory.
interface dmem_access_unit_if #(
    parameter int ADDR_W = 32
) ();
    logic              req_valid_in;
    logic              req_ready_out;
    logic              req_we_in;
    logic [2:0]        funct3_in;
    logic [ADDR_W-1:0] addr_in;
    logic [31:0]       wdata_in;
    logic              mem_req_out;
    logic              mem_we_out;
    logic [ADDR_W-1:0] mem_addr_out;
    logic [3:0]        mem_be_out;
    logic [31:0]       mem_wdata_out;
    logic              mem_ack_in;
    logic [31:0]       mem_rdata_in;
    logic [31:0]       load_data_out;
    logic [2:0]        load_funct3_out;
    logic              load_valid_out;
    logic              stall_out;
    logic              misalign_out;

    modport slave (
        input  req_valid_in, req_we_in, funct3_in, addr_in, wdata_in,
        input  mem_ack_in, mem_rdata_in,
        output req_ready_out, mem_req_out, mem_we_out, mem_addr_out, mem_be_out,
        output mem_wdata_out, load_data_out, load_funct3_out, load_valid_out,
        output stall_out, misalign_out
    );

    modport master (
        output req_valid_in, req_we_in, funct3_in, addr_in, wdata_in,
        output mem_ack_in, mem_rdata_in,
        input  req_ready_out, mem_req_out, mem_we_out, mem_addr_out, mem_be_out,
        input  mem_wdata_out, load_data_out, load_funct3_out, load_valid_out,
        input  stall_out, misalign_out
    );
endinterface

// File: rtl/dmem_access_unit.sv
// Data-memory access stage: one load/store per handshake, stalls until memory ack.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses pulse misalign_out instead of issuing.
module dmem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic                clk_in,
    input  logic                rst_in,
    dmem_access_unit_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_we;
    logic [2:0]        r_funct3;
    logic [1:0]        r_off;
    logic              r_ready;
    logic              r_stall;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [3:0]        r_mem_be;
    logic [31:0]       r_mem_wdata;
    logic [31:0]       r_load_data;
    logic [2:0]        r_load_funct3;
    logic              r_load_valid;
    logic              r_misalign;

    logic [1:0]        w_off;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic              w_misal;
    logic [31:0]       w_rshift;

    assign w_off = bus.addr_in[1:0];

    // Byte-enable and lane replication for the incoming request
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = bus.wdata_in;
        if (!bus.req_we_in) begin
            w_be    = 4'b1111;
            w_wdata = bus.wdata_in;
        end else if (bus.funct3_in[1]) begin
            w_be    = 4'b1111;
            w_wdata = bus.wdata_in;
        end else if (bus.funct3_in[0]) begin
            w_be    = 4'b0011 << {w_off[1], 1'b0};
            w_wdata = {2{bus.wdata_in[15:0]}};
        end else begin
            w_be    = 4'b0001 << w_off;
            w_wdata = {4{bus.wdata_in[7:0]}};
        end
    end

    // Misalignment detection; without the trap the low bits are simply truncated
    always_comb begin
`ifdef DMEM_MISALIGN_TRAP_EN
        w_misal = (bus.funct3_in[1] && (w_off != 2'b00)) ||
                  (!bus.funct3_in[1] && bus.funct3_in[0] && w_off[0]);
`else
        w_misal = 1'b0;
`endif
    end

    // Read data moved down to lane 0 with zero fill; extension is load_unit's job
    always_comb begin
        w_rshift = bus.mem_rdata_in;
        if (r_funct3[1]) begin
            w_rshift = bus.mem_rdata_in;
        end else if (r_funct3[0]) begin
            w_rshift = bus.mem_rdata_in >> {r_off[1], 4'b0000};
        end else begin
            w_rshift = bus.mem_rdata_in >> {r_off, 3'b000};
        end
    end

    // Access FSM with all outputs registered
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state       <= S_IDLE;
            r_we          <= 1'b0;
            r_funct3      <= 3'b000;
            r_off         <= 2'b00;
            r_ready       <= 1'b1;
            r_stall       <= 1'b0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= {ADDR_W{1'b0}};
            r_mem_be      <= 4'b0000;
            r_mem_wdata   <= 32'h0000_0000;
            r_load_data   <= 32'h0000_0000;
            r_load_funct3 <= 3'b000;
            r_load_valid  <= 1'b0;
            r_misalign    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid_in) begin
                        r_ready <= 1'b0;
                        r_stall <= 1'b1;
                        if (w_misal) begin
                            r_misalign <= 1'b1;
                            r_state    <= S_RESP;
                        end else begin
                            r_we        <= bus.req_we_in;
                            r_funct3    <= bus.funct3_in;
                            r_off       <= w_off;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= bus.req_we_in;
                            r_mem_addr  <= {bus.addr_in[ADDR_W-1:2], 2'b00};
                            r_mem_be    <= w_be;
                            r_mem_wdata <= w_wdata;
                            r_state     <= S_BUSY;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (bus.mem_ack_in) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        if (r_we) begin
                            r_ready <= 1'b1;
                            r_stall <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_load_data   <= w_rshift;
                            r_load_funct3 <= r_funct3;
                            r_load_valid  <= 1'b1;
                            r_state       <= S_RESP;
                        end
                    end else begin
                        r_state <= S_BUSY;
                    end
                end
                S_RESP: begin
                    r_load_valid <= 1'b0;
                    r_misalign   <= 1'b0;
                    r_ready      <= 1'b1;
                    r_stall      <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_mem_req    <= 1'b0;
                    r_mem_we     <= 1'b0;
                    r_load_valid <= 1'b0;
                    r_misalign   <= 1'b0;
                    r_ready      <= 1'b1;
                    r_stall      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready_out   = r_ready;
    assign bus.stall_out       = r_stall;
    assign bus.mem_req_out     = r_mem_req;
    assign bus.mem_we_out      = r_mem_we;
    assign bus.mem_addr_out    = r_mem_addr;
    assign bus.mem_be_out      = r_mem_be;
    assign bus.mem_wdata_out   = r_mem_wdata;
    assign bus.load_data_out   = r_load_data;
    assign bus.load_funct3_out = r_load_funct3;
    assign bus.load_valid_out  = r_load_valid;
    assign bus.misalign_out    = r_misalign;
endmodule
